led_flow_seq: RTL and testbench
===============================

Name: led_flow_seq

Overview:
Downstream consumer of a periodic one-cycle tick pulse, such as the flag from a max-count prescaler. It drives an LED bank through a fixed light-show cycle: flow left, then flow right, then blink-all, repeating. Each pattern runs for REPEAT sweeps before the state machine moves to the next one. The block is the visible-output stage after the tick generator.

Parameters:
LED_NUM, 4, number of LEDs driven; legal range 2..16.
REPEAT, 2, number of complete sweeps per pattern before advancing; legal range 1..255.

Ports:
sys_clk  input  1  system clock; the single clock domain.
sys_rst_n  input  1  asynchronous reset, active-low.
tick_in  input  1  advance strobe, sampled every sys_clk rising edge; each high cycle = one step.
hold  input  1  level; while high, tick_in is ignored. Ignored ticks are dropped, not queued.
led_out  output  LED_NUM  registered LED drive, active-high.
state_out  output  2  current pattern: 0 = LEFT, 1 = RIGHT, 2 = BLINK; 3 is never produced.
sweep_done  output  1  one-cycle pulse on the cycle in which a sweep completes.

Behaviour:
- Reset (asynchronous, active-low sys_rst_n; takes effect mid-operation too):
  - state = LEFT, pos = 0, sweep_cnt = 0, phase = 0.
  - led_out = 1 (bit 0 lit), state_out = 0, sweep_done = 0.
- Step = (tick_in && !hold) at a rising edge. All outputs are registered; the effect of a step is visible on the edge that samples it (1-cycle latency). With no step, all state holds and sweep_done = 0.
- LEFT:
  - Step with pos < LED_NUM-1: pos+1.
  - Step with pos == LED_NUM-1: end of sweep.
  - led_out = one-hot at pos.
- RIGHT:
  - Step with pos > 0: pos-1.
  - Step with pos == 0: end of sweep.
  - led_out = one-hot at pos.
- BLINK:
  - phase 0: led_out = all ones.
  - phase 1: led_out = all zeros.
  - Step at phase 0: go to phase 1.
  - Step at phase 1: end of sweep, phase returns to 0.
- End of sweep:
  - sweep_done = 1 for that one cycle.
  - If sweep_cnt < REPEAT-1: sweep_cnt+1; pattern restarts (LEFT pos = 0, RIGHT pos = LED_NUM-1, BLINK phase = 0).
  - Else: sweep_cnt = 0 and state advances LEFT -> RIGHT -> BLINK -> LEFT.
    - Entering RIGHT: pos = LED_NUM-1 (led_out = MSB).
    - Entering BLINK: phase = 0 (all on).
    - Entering LEFT: pos = 0 (led_out = 1).
- Ticks per full cycle = 2*LED_NUM*REPEAT + 2*REPEAT.
- hold asserted together with tick_in: no step, no sweep_done.
- Consecutive tick_in high cycles: each cycle is one step; no edge detection.
- pos is sized ceil(log2(LED_NUM)) bits and never leaves 0..LED_NUM-1. sweep_cnt is 8 bits. No wrap beyond the stated ranges.

Optional Feature:
LED_FLOW_SKIP_EN
- Defined: adds input port skip (1 bit), placed after hold.
  - skip high at an edge forces an immediate pattern advance: next state, entry values, sweep_cnt = 0, sweep_done = 1.
  - skip takes priority over tick_in and acts even while hold is high.
- Undefined: no skip port; pattern changes only via sweep completion.

Test Plan:
1. Reset release, LED_NUM=4, REPEAT=2, ticks 1..3 -> led_out 0010, 0100, 1000; state_out=0; sweep_done low.
2. Continue to tick 4 -> sweep_done pulse, led_out=0001; tick 8 -> sweep_done, state_out=1, led_out=1000.
3. Ticks 9..16 -> descending pattern, sweep_done on 12 and 16; tick 16 -> state_out=2, led_out=1111; ticks 17..20 -> 0000, 1111, 0000, then 0001 with state_out=0.
4. hold=1 with 5 tick pulses mid-LEFT at led_out=0100 -> led_out, state_out unchanged, sweep_done never high; release hold, 1 tick -> 1000.
5. tick_in held high for 3 consecutive cycles from reset -> led_out 0010, 0100, 1000 on successive edges.
6. sys_rst_n low for a fraction of a cycle during RIGHT at led_out=0010 -> led_out=0001, state_out=0 immediately; with LED_FLOW_SKIP_EN, skip pulse in LEFT with hold=1 -> state_out=1, led_out=1000, sweep_done=1.

Source files
------------

// File: rtl/led_flow_seq.sv
// ---------------------------------------------------------------------------
// led_flow_seq
// LED light-show sequencer driven by a periodic one-cycle tick. Cycles through
// three patterns: flow left, flow right, blink-all. Each pattern runs for
// REPEAT sweeps before advancing to the next one.
//
// Parameters:
//   LED_NUM  number of LEDs (2..16)
//   REPEAT   sweeps per pattern before advancing (1..255)
//
// Ports:
//   sys_clk     system clock
//   sys_rst_n   asynchronous reset, active-low
//   tick_in     advance strobe; each high cycle is one step
//   hold        while high, tick_in is ignored (ticks dropped, not queued)
//   skip        (LED_FLOW_SKIP_EN only) force an immediate pattern advance
//   led_out     registered LED drive, active-high
//   state_out   current pattern: 0 LEFT, 1 RIGHT, 2 BLINK
//   sweep_done  one-cycle pulse on the cycle a sweep completes
//
// Optional feature macro: LED_FLOW_SKIP_EN (adds the skip input).
// ---------------------------------------------------------------------------
module led_flow_seq #(
    parameter int LED_NUM = 4,
    parameter int REPEAT  = 2
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               tick_in,
    input  logic               hold,
`ifdef LED_FLOW_SKIP_EN
    input  logic               skip,
`endif
    output logic [LED_NUM-1:0] led_out,
    output logic [1:0]         state_out,
    output logic               sweep_done
);

    localparam int POS_W = $clog2(LED_NUM);

    localparam logic [1:0] ST_LEFT  = 2'd0;
    localparam logic [1:0] ST_RIGHT = 2'd1;
    localparam logic [1:0] ST_BLINK = 2'd2;

    localparam logic [POS_W-1:0]   POS_MAX  = POS_W'(LED_NUM - 1);
    localparam logic [7:0]         CNT_LAST = 8'(REPEAT - 1);
    localparam logic [LED_NUM-1:0] LED_ONE  = LED_NUM'(1);

    logic [1:0]         state, state_nxt;
    logic [POS_W-1:0]   pos, pos_nxt;
    logic [7:0]         sweep_cnt, cnt_nxt;
    logic               phase, phase_nxt;
    logic [LED_NUM-1:0] led_nxt;
    logic               done_nxt;

    logic               step;
    logic               skip_w;
    logic               end_sweep;
    logic               reload;
    logic [1:0]         nxt_pat;
    logic [1:0]         tgt;

`ifdef LED_FLOW_SKIP_EN
    assign skip_w = skip;
`else
    assign skip_w = 1'b0;
`endif

    assign step = tick_in && !hold;

    always_comb begin
        case (state)
            ST_LEFT:  nxt_pat = ST_RIGHT;
            ST_RIGHT: nxt_pat = ST_BLINK;
            default:  nxt_pat = ST_LEFT;
        endcase
    end

    always_comb begin
        state_nxt = state;
        pos_nxt   = pos;
        cnt_nxt   = sweep_cnt;
        phase_nxt = phase;
        done_nxt  = 1'b0;
        end_sweep = 1'b0;
        reload    = 1'b0;
        tgt       = state;

        if (skip_w) begin
            // skip overrides both tick and hold
            reload   = 1'b1;
            tgt      = nxt_pat;
            cnt_nxt  = 8'd0;
            done_nxt = 1'b1;
        end else if (step) begin
            case (state)
                ST_LEFT: begin
                    if (pos == POS_MAX) end_sweep = 1'b1;
                    else                pos_nxt   = pos + 1'b1;
                end
                ST_RIGHT: begin
                    if (pos == '0) end_sweep = 1'b1;
                    else           pos_nxt   = pos - 1'b1;
                end
                ST_BLINK: begin
                    if (!phase) phase_nxt = 1'b1;
                    else        end_sweep = 1'b1;
                end
                default: end_sweep = 1'b1;
            endcase

            if (end_sweep) begin
                done_nxt = 1'b1;
                reload   = 1'b1;
                if (state != ST_BLINK && state != ST_RIGHT && state != ST_LEFT) begin
                    // unreachable encoding: recover into LEFT
                    cnt_nxt = 8'd0;
                    tgt     = ST_LEFT;
                end else if (sweep_cnt < CNT_LAST) begin
                    cnt_nxt = sweep_cnt + 8'd1;
                end else begin
                    cnt_nxt = 8'd0;
                    tgt     = nxt_pat;
                end
            end
        end

        // Entry values for a restarted or newly entered pattern
        if (reload) begin
            state_nxt = tgt;
            pos_nxt   = (tgt == ST_RIGHT) ? POS_MAX : '0;
            phase_nxt = 1'b0;
        end
    end

    // LED drive is derived from the next state so it updates on the same edge
    always_comb begin
        case (state_nxt)
            ST_LEFT, ST_RIGHT: led_nxt = LED_ONE << pos_nxt;
            ST_BLINK:          led_nxt = phase_nxt ? '0 : '1;
            default:           led_nxt = LED_ONE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= ST_LEFT;
            pos        <= '0;
            sweep_cnt  <= 8'd0;
            phase      <= 1'b0;
            led_out    <= LED_ONE;
            sweep_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            pos        <= pos_nxt;
            sweep_cnt  <= cnt_nxt;
            phase      <= phase_nxt;
            led_out    <= led_nxt;
            sweep_done <= done_nxt;
        end
    end

    assign state_out = state;

endmodule

// File: tb/tb_led_flow_seq.sv
module tb_led_flow_seq;

    localparam int L = 4;
    localparam int R = 2;
    localparam int LR = L * R;
    localparam int T = 2 * L * R + 2 * R;

    logic         sys_clk;
    logic         sys_rst_n;
    logic         tick_in;
    logic         hold;
    logic         skip;
    logic [L-1:0] led_out;
    logic [1:0]   state_out;
    logic         sweep_done;

    int cmp_cnt = 0;
    int err_cnt = 0;

    // Reference model: number of steps taken since reset, interpreted
    // against the fixed light-show timeline.
    int n;
    logic exp_done;

    led_flow_seq #(.LED_NUM(L), .REPEAT(R)) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .tick_in    (tick_in),
        .hold       (hold),
`ifdef LED_FLOW_SKIP_EN
        .skip       (skip),
`endif
        .led_out    (led_out),
        .state_out  (state_out),
        .sweep_done (sweep_done)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    function automatic logic [1:0] exp_state(input int k);
        int m;
        m = k % T;
        if (m < LR)          return 2'd0;
        else if (m < 2 * LR) return 2'd1;
        else                 return 2'd2;
    endfunction

    function automatic logic [L-1:0] exp_led(input int k);
        int m;
        logic [L-1:0] v;
        m = k % T;
        v = '0;
        if (m < LR)          v[m % L] = 1'b1;
        else if (m < 2 * LR) v[L - 1 - ((m - LR) % L)] = 1'b1;
        else if (((m - 2 * LR) % 2) == 0) v = '1;
        return v;
    endfunction

    function automatic logic at_boundary(input int k);
        int m;
        m = k % T;
        if (m < 2 * LR) return (m % L) == 0;
        else            return ((m - 2 * LR) % 2) == 0;
    endfunction

    // Drive one cycle of inputs (called at a negedge) and advance the model;
    // returns at the following negedge, where outputs are stable.
    task automatic drive(input logic t, input logic h, input logic s);
        int m;
        tick_in = t;
        hold    = h;
        skip    = s;
        @(posedge sys_clk);
`ifdef LED_FLOW_SKIP_EN
        if (s) begin
            m = n % T;
            n = n - m + ((m < LR) ? LR : (m < 2 * LR) ? 2 * LR : T);
            exp_done = 1'b1;
        end else
`endif
        if (t && !h) begin
            n = n + 1;
            exp_done = at_boundary(n);
        end else begin
            exp_done = 1'b0;
        end
        @(negedge sys_clk);
        tick_in = 1'b0;
        hold    = 1'b0;
        skip    = 1'b0;
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        tick_in = 1'b0;
        hold = 1'b0;
        skip = 1'b0;
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        n = 0;
        exp_done = 1'b0;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        tick_in = 1'b0;
        hold = 1'b0;
        skip = 1'b0;
        @(negedge sys_clk);
        cmp_cnt++;
        if (led_out !== 4'b0001 || state_out !== 2'd0 || sweep_done !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset: led=%b state=%0d done=%b, expected led=0001 state=0 done=0",
                     led_out, state_out, sweep_done);
        end
        do_reset();
    endtask

    // Full light-show cycle, one tick followed by one idle cycle each.
    task automatic test_flow_cycle();
        do_reset();
        for (int i = 1; i <= T; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            cmp_cnt++;
            if (led_out !== exp_led(n) || state_out !== exp_state(n) || sweep_done !== exp_done) begin
                err_cnt++;
                $display("FAIL flow tick %0d: led=%b state=%0d done=%b, expected led=%b state=%0d done=%b",
                         i, led_out, state_out, sweep_done, exp_led(n), exp_state(n), exp_done);
            end
            if (i == 4 || i == 8 || i == 16 || i == 20) begin
                cmp_cnt++;
                if (sweep_done !== 1'b1 ||
                    (i == 4  && (led_out !== 4'b0001 || state_out !== 2'd0)) ||
                    (i == 8  && (led_out !== 4'b1000 || state_out !== 2'd1)) ||
                    (i == 16 && (led_out !== 4'b1111 || state_out !== 2'd2)) ||
                    (i == 20 && (led_out !== 4'b0001 || state_out !== 2'd0))) begin
                    err_cnt++;
                    $display("FAIL flow milestone tick %0d: led=%b state=%0d done=%b",
                             i, led_out, state_out, sweep_done);
                end
            end
            drive(1'b0, 1'b0, 1'b0);
            cmp_cnt++;
            if (sweep_done !== 1'b0 || led_out !== exp_led(n)) begin
                err_cnt++;
                $display("FAIL flow idle after %0d: led=%b done=%b, expected led=%b done=0",
                         i, led_out, sweep_done, exp_led(n));
            end
        end
    endtask

    task automatic test_hold();
        do_reset();
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 1'b0);
            drive(1'b0, 1'b1, 1'b0);
            cmp_cnt++;
            if (led_out !== 4'b0100 || state_out !== 2'd0 || sweep_done !== 1'b0) begin
                err_cnt++;
                $display("FAIL hold %0d: led=%b state=%0d done=%b, expected led=0100 state=0 done=0",
                         i, led_out, state_out, sweep_done);
            end
        end
        drive(1'b1, 1'b0, 1'b0);
        cmp_cnt++;
        if (led_out !== 4'b1000 || state_out !== 2'd0) begin
            err_cnt++;
            $display("FAIL hold release: led=%b state=%0d, expected led=1000 state=0",
                     led_out, state_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [L-1:0] want [3];
        want[0] = 4'b0010;
        want[1] = 4'b0100;
        want[2] = 4'b1000;
        do_reset();
        tick_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge sys_clk);
            n = n + 1;
            @(negedge sys_clk);
            cmp_cnt++;
            if (led_out !== want[i] || led_out !== exp_led(n)) begin
                err_cnt++;
                $display("FAIL back_to_back %0d: led=%b, expected %b", i, led_out, want[i]);
            end
        end
        tick_in = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < LR + 2; i++) drive(1'b1, 1'b0, 1'b0);
        cmp_cnt++;
        if (led_out !== 4'b0010 || state_out !== 2'd1) begin
            err_cnt++;
            $display("FAIL async_reset setup: led=%b state=%0d, expected led=0010 state=1",
                     led_out, state_out);
        end
        #1 sys_rst_n = 1'b0;
        #1;
        cmp_cnt++;
        if (led_out !== 4'b0001 || state_out !== 2'd0 || sweep_done !== 1'b0) begin
            err_cnt++;
            $display("FAIL async_reset: led=%b state=%0d done=%b, expected led=0001 state=0 done=0",
                     led_out, state_out, sweep_done);
        end
        #1 sys_rst_n = 1'b1;
        n = 0;
        exp_done = 1'b0;
        @(negedge sys_clk);
        drive(1'b1, 1'b0, 1'b0);
        cmp_cnt++;
        if (led_out !== 4'b0010 || state_out !== 2'd0) begin
            err_cnt++;
            $display("FAIL async_reset resume: led=%b state=%0d, expected led=0010 state=0",
                     led_out, state_out);
        end
    endtask

    task automatic test_skip();
`ifdef LED_FLOW_SKIP_EN
        do_reset();
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1);
        cmp_cnt++;
        if (state_out !== 2'd1 || led_out !== 4'b1000 || sweep_done !== 1'b1) begin
            err_cnt++;
            $display("FAIL skip: led=%b state=%0d done=%b, expected led=1000 state=1 done=1",
                     led_out, state_out, sweep_done);
        end
`endif
    endtask

    task automatic test_random();
        logic t, h, s;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            t = ($urandom_range(0, 3) != 0);
            h = ($urandom_range(0, 3) == 0);
`ifdef LED_FLOW_SKIP_EN
            s = ($urandom_range(0, 19) == 0);
`else
            s = 1'b0;
`endif
            drive(t, h, s);
            cmp_cnt++;
            if (led_out !== exp_led(n) || state_out !== exp_state(n) || sweep_done !== exp_done) begin
                err_cnt++;
                $display("FAIL random %0d: led=%b state=%0d done=%b, expected led=%b state=%0d done=%b",
                         i, led_out, state_out, sweep_done, exp_led(n), exp_state(n), exp_done);
            end
        end
    endtask

    initial begin
        n = 0;
        exp_done = 1'b0;
        test_reset();
        test_flow_cycle();
        test_hold();
        test_back_to_back();
        test_async_reset();
        test_skip();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
